// File: rtl/calc_arbiter.sv
// calc_arbiter: two-port round-robin arbiter and sequencer for the shared
// calculator datapath. One operation is in flight at a time. The block
// waits LATENCY edges for the result, then holds it until it is consumed.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req{0,1}_valid/_ready           request handshakes (ready is combinational)
//   req{0,1}_op/_a/_b               request operation code and operands
//   calc_op/_a/_b                   registered launch values to the calculator
//   calc_result                     calculator result (2*WIDTH bits)
//   rsp_valid/_ready/_id/_result    response channel, held while in RESP
//   busy                            high whenever the sequencer is not idle
module calc_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [1:0]           req0_op,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [1:0]           req1_op,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic [1:0]           calc_op,
    output logic [WIDTH-1:0]     calc_a,
    output logic [WIDTH-1:0]     calc_b,
    input  logic [2*WIDTH-1:0]   calc_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [2*WIDTH-1:0]   rsp_result,
    output logic                 busy
);

    localparam int unsigned RES_W = 2 * WIDTH;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e              state_q;
    logic                last_grant_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [1:0]          calc_op_q;
    logic [WIDTH-1:0]    calc_a_q;
    logic [WIDTH-1:0]    calc_b_q;
    logic                rsp_id_q;
    logic [RES_W-1:0]    rsp_result_q;

    logic                gnt_valid;
    logic                gnt_idx;
    logic                launch;
    logic [1:0]          calc_op_d;
    logic [WIDTH-1:0]    calc_a_d;
    logic [WIDTH-1:0]    calc_b_d;

    // Round-robin pick: on a tie the port that did not win last time goes.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_valid = 1'b1;
            gnt_idx   = ~last_grant_q;
        end else if (req0_valid) begin
            gnt_valid = 1'b1;
            gnt_idx   = 1'b0;
        end else if (req1_valid) begin
            gnt_valid = 1'b1;
            gnt_idx   = 1'b1;
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        calc_op_d = gnt_idx ? req1_op : req0_op;
        calc_a_d  = gnt_idx ? req1_a  : req0_a;
        calc_b_d  = gnt_idx ? req1_b  : req0_b;
    end

    assign launch     = (state_q == ST_IDLE) && gnt_valid;
    // Gated by rst_n so neither requester sees ready while reset is held.
    assign req0_ready = rst_n && launch && !gnt_idx;
    assign req1_ready = rst_n && launch &&  gnt_idx;

    // Sequencer: launch, count down the pipeline latency, hold the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            calc_op_q    <= '0;
            calc_a_q     <= '0;
            calc_b_q     <= '0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        calc_op_q    <= calc_op_d;
                        calc_a_q     <= calc_a_d;
                        calc_b_q     <= calc_b_d;
                        rsp_id_q     <= gnt_idx;
                        last_grant_q <= gnt_idx;
                        cnt_q        <= CNT_W'(LATENCY - 1);
                        state_q      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        rsp_result_q <= calc_result;
                        state_q      <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign calc_op    = calc_op_q;
    assign calc_a     = calc_a_q;
    assign calc_b     = calc_b_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_valid  = (state_q == ST_RESP);
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_calc_arbiter.sv
// Bench for calc_arbiter: three instances (LATENCY 2, 1, 15) share inputs,
// each with its own behavioural calculator. Instance 0 is tracked every
// cycle by a transaction-level reference model.
module tb_calc_arbiter;

    localparam int unsigned W  = 32;
    localparam int unsigned RW = 2 * W;
    localparam int unsigned NI = 3;
    localparam int unsigned L0 = 2;

    function automatic int unsigned lat_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    endfunction

    function automatic logic [RW-1:0] calc_f(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (op)
            2'd0:    return RW'(a) + RW'(b);
            2'd1:    return RW'(a) - RW'(b);
            2'd2:    return RW'(a) * RW'(b);
            default: return (b == '0) ? '1 : RW'(a / b);
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst_n;
    logic req0_valid, req1_valid, rsp_ready;
    logic [1:0] req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;

    logic r0_rdy [NI];
    logic r1_rdy [NI];
    logic rv     [NI];
    logic rid    [NI];
    logic bsy    [NI];
    logic [1:0]    c_op  [NI];
    logic [W-1:0]  c_a   [NI];
    logic [W-1:0]  c_b   [NI];
    logic [RW-1:0] c_res [NI];
    logic [RW-1:0] r_res [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int unsigned L = lat_of(g);
        logic [RW-1:0] pipe [16];

        // Behavioural calculator: result valid L edges after its inputs change.
        always @(posedge clk) begin
            pipe[0] <= calc_f(c_op[g], c_a[g], c_b[g]);
            for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
        end
        if (L == 1) begin : g_comb
            assign c_res[g] = calc_f(c_op[g], c_a[g], c_b[g]);
        end else begin : g_pipe
            assign c_res[g] = pipe[L-2];
        end

        calc_arbiter #(.WIDTH(W), .LATENCY(L)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .req0_valid(req0_valid), .req0_ready(r0_rdy[g]), .req0_op(req0_op),
            .req0_a(req0_a), .req0_b(req0_b),
            .req1_valid(req1_valid), .req1_ready(r1_rdy[g]), .req1_op(req1_op),
            .req1_a(req1_a), .req1_b(req1_b),
            .calc_op(c_op[g]), .calc_a(c_a[g]), .calc_b(c_b[g]),
            .calc_result(c_res[g]),
            .rsp_valid(rv[g]), .rsp_ready(rsp_ready), .rsp_id(rid[g]),
            .rsp_result(r_res[g]), .busy(bsy[g])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: one operation outstanding, timed by cycle stamps.
    bit            m_pend, m_last, m_id;
    longint        t, t_launch;
    logic [1:0]    m_op;
    logic [W-1:0]  m_a, m_b;
    logic [RW-1:0] m_pend_res, m_res;

    task automatic model_reset();
        m_pend = 0; m_last = 1; m_id = 0;
        m_op = '0; m_a = '0; m_b = '0;
        m_pend_res = '0; m_res = '0;
    endtask

    function automatic logic [1:0] ref_grant();
        if (req0_valid && req1_valid) return {1'b1, ~m_last};
        if (req0_valid) return 2'b10;
        if (req1_valid) return 2'b11;
        return 2'b00;
    endfunction

    function automatic bit ref_rsp_valid();
        return m_pend && (t >= t_launch + longint'(L0));
    endfunction

    task automatic model_edge();
        logic [1:0] gr;
        bit         rvv;
        gr  = ref_grant();
        rvv = ref_rsp_valid();
        t++;
        if (!rst_n) begin
            model_reset();
        end else if (m_pend) begin
            if (rvv && rsp_ready) m_pend = 0;
            else if (t == t_launch + longint'(L0)) m_res = m_pend_res;
        end else if (gr[1]) begin
            m_pend = 1; t_launch = t; m_last = gr[0]; m_id = gr[0];
            m_op = gr[0] ? req1_op : req0_op;
            m_a  = gr[0] ? req1_a  : req0_a;
            m_b  = gr[0] ? req1_b  : req0_b;
            m_pend_res = calc_f(m_op, m_a, m_b);
        end
    endtask

    function automatic logic [159:0] obs_exp();
        logic [1:0] gr;
        logic e_r0, e_r1;
        gr   = ref_grant();
        e_r0 = rst_n && !m_pend && gr[1] && !gr[0];
        e_r1 = rst_n && !m_pend && gr[1] &&  gr[0];
        return 160'({e_r0, e_r1, ref_rsp_valid(), m_id, m_pend, m_op, m_a, m_b, m_res});
    endfunction

    function automatic logic [159:0] obs_act();
        return 160'({r0_rdy[0], r1_rdy[0], rv[0], rid[0], bsy[0], c_op[0], c_a[0], c_b[0], r_res[0]});
    endfunction

    bit            snap_rv  [NI];
    bit            snap_id  [NI];
    bit            snap_r1  [NI];
    logic [RW-1:0] snap_res [NI];

    // One clock: compare instance 0 against the model mid-cycle, advance model.
    task automatic cyc();
        @(negedge clk);
        chk("model", obs_act(), obs_exp());
        for (int g = 0; g < NI; g++) begin
            snap_rv[g] = rv[g]; snap_id[g] = rid[g];
            snap_r1[g] = r1_rdy[g]; snap_res[g] = r_res[g];
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0;
        req0_op = '0; req0_a = '0; req0_b = '0;
        req1_op = '0; req1_a = '0; req1_b = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rsp_ready = 1;
        rst_n = 0;
        model_reset();
        cyc(); cyc();
        rst_n = 1;
    endtask

    typedef struct {
        bit rst; bit v0; logic [1:0] op0; logic [W-1:0] a0, b0;
        bit v1; logic [1:0] op1; logic [W-1:0] a1, b1; bit rr;
        bit e_r0, e_r1, e_rv, e_id, e_busy; logic [RW-1:0] e_res;
    } vec_t;

    function automatic vec_t mk(input bit rst, input bit v0, input logic [1:0] op0,
                                input logic [W-1:0] a0, input logic [W-1:0] b0,
                                input bit v1, input logic [1:0] op1,
                                input logic [W-1:0] a1, input logic [W-1:0] b1, input bit rr,
                                input bit er0, input bit er1, input bit erv, input bit eid,
                                input bit ebusy, input logic [RW-1:0] eres);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.op0 = op0; v.a0 = a0; v.b0 = b0;
        v.v1 = v1; v.op1 = op1; v.a1 = a1; v.b1 = b1; v.rr = rr;
        v.e_r0 = er0; v.e_r1 = er1; v.e_rv = erv; v.e_id = eid; v.e_busy = ebusy; v.e_res = eres;
        return v;
    endfunction

    vec_t tbl[$];
    int   first_rise [NI];
    int   second_rise[NI];
    logic [RW-1:0] first_res[NI];
    bit   prev_rv[NI];
    int   id1_rsp, id1_rdy, rsp_count;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        rsp_ready = 1;
        idle_inputs();
        t = 0; t_launch = 0;
        model_reset();

        // Single request (12*5), then contention after reset (3+4 vs 9-2).
        //           rst v0 op a  b   v1 op a  b  rr   r0 r1 rv id bz res
        tbl.push_back(mk(1, 0,0, 0, 0, 0,0,0,0, 1,  0,0,0,0,0, 0));
        tbl.push_back(mk(0, 1,2,12, 5, 0,0,0,0, 1,  1,0,0,0,0, 0));
        tbl.push_back(mk(0, 0,0, 0, 0, 0,0,0,0, 1,  0,0,0,0,1, 0));
        tbl.push_back(mk(0, 0,0, 0, 0, 0,0,0,0, 1,  0,0,0,0,1, 0));
        tbl.push_back(mk(0, 0,0, 0, 0, 0,0,0,0, 1,  0,0,1,0,1, 60));
        tbl.push_back(mk(0, 0,0, 0, 0, 0,0,0,0, 1,  0,0,0,0,0, 60));
        tbl.push_back(mk(1, 0,0, 0, 0, 0,0,0,0, 1,  0,0,0,0,0, 0));
        tbl.push_back(mk(0, 1,0, 3, 4, 1,1,9,2, 1,  1,0,0,0,0, 0));
        tbl.push_back(mk(0, 1,0, 3, 4, 1,1,9,2, 1,  0,0,0,0,1, 0));
        tbl.push_back(mk(0, 1,0, 3, 4, 1,1,9,2, 1,  0,0,0,0,1, 0));
        tbl.push_back(mk(0, 1,0, 3, 4, 1,1,9,2, 1,  0,0,1,0,1, 7));
        tbl.push_back(mk(0, 1,0, 3, 4, 1,1,9,2, 1,  0,1,0,0,0, 7));
        tbl.push_back(mk(0, 1,0, 3, 4, 1,1,9,2, 1,  0,0,0,1,1, 7));
        tbl.push_back(mk(0, 1,0, 3, 4, 1,1,9,2, 1,  0,0,0,1,1, 7));
        tbl.push_back(mk(0, 1,0, 3, 4, 1,1,9,2, 1,  0,0,1,1,1, 7));
        tbl.push_back(mk(0, 1,0, 3, 4, 1,1,9,2, 1,  1,0,0,1,0, 7));
        tbl.push_back(mk(0, 1,0, 3, 4, 1,1,9,2, 1,  0,0,0,0,1, 7));

        foreach (tbl[i]) begin
            rst_n = !tbl[i].rst;
            if (tbl[i].rst) model_reset();
            req0_valid = tbl[i].v0; req0_op = tbl[i].op0; req0_a = tbl[i].a0; req0_b = tbl[i].b0;
            req1_valid = tbl[i].v1; req1_op = tbl[i].op1; req1_a = tbl[i].a1; req1_b = tbl[i].b1;
            rsp_ready  = tbl[i].rr;
            @(negedge clk);
            chk("model", obs_act(), obs_exp());
            chk($sformatf("table_row%0d", i),
                160'({r0_rdy[0], r1_rdy[0], rv[0], rid[0], bsy[0], r_res[0]}),
                160'({tbl[i].e_r0, tbl[i].e_r1, tbl[i].e_rv, tbl[i].e_id, tbl[i].e_busy, tbl[i].e_res}));
            @(posedge clk);
            model_edge();
            #1;
        end
        rst_n = 1;

        // Backpressure: RESP held 10 extra cycles with req1 waiting.
        do_reset();
        req0_valid = 1; req0_op = 2'd2; req0_a = 12; req0_b = 5;
        cyc();
        req0_valid = 0; rsp_ready = 0;
        req1_valid = 1; req1_op = 2'd3; req1_a = 100; req1_b = 7;
        for (int i = 0; i < 12; i++) cyc();
        chk("bp_hold", 160'({rv[0], rid[0], r1_rdy[0], r_res[0], c_op[0], c_a[0], c_b[0]}),
            160'({1'b1, 1'b0, 1'b0, RW'(60), 2'd2, W'(12), W'(5)}));
        rsp_ready = 1;
        cyc();
        chk("bp_req1_ready_after", 160'(r1_rdy[0]), 160'(1));
        cyc();
        req1_valid = 0;
        cyc(); cyc();
        chk("bp_req1_rsp", 160'({rv[0], rid[0], r_res[0]}), 160'({1'b1, 1'b1, RW'(14)}));
        cyc();

        // Reset during WAIT drops the operation.
        do_reset();
        req0_valid = 1; req0_op = 2'd0; req0_a = 5; req0_b = 6;
        cyc();
        rst_n = 0;
        model_reset();
        #1;
        chk("rst_midwait_outputs", obs_act(), 160'(0));
        cyc(); cyc();
        rst_n = 1;
        req0_valid = 0;
        for (int i = 0; i < 6; i++) cyc();
        chk("rst_no_stray_rsp", 160'({rv[0], bsy[0]}), 160'(0));
        req0_valid = 1; req0_op = 2'd2; req0_a = 7; req0_b = 8;
        cyc();
        req0_valid = 0;
        cyc(); cyc();
        chk("rst_next_req", 160'({rv[0], rid[0], r_res[0]}), 160'({1'b1, 1'b0, RW'(56)}));
        cyc();

        // Latency 2/1/15: result timing and back-to-back period.
        do_reset();
        req0_valid = 1; req0_op = 2'd0; req0_a = 32'hFFFF_FFFF; req0_b = 1;
        for (int g = 0; g < NI; g++) begin
            first_rise[g] = -1; second_rise[g] = -1; first_res[g] = '0; prev_rv[g] = 0;
        end
        for (int n = 0; n < 50; n++) begin
            cyc();
            for (int g = 0; g < NI; g++) begin
                if (snap_rv[g] && !prev_rv[g]) begin
                    if (first_rise[g] < 0) begin
                        first_rise[g] = n; first_res[g] = snap_res[g];
                    end else if (second_rise[g] < 0) begin
                        second_rise[g] = n;
                    end
                end
                prev_rv[g] = snap_rv[g];
            end
        end
        req0_valid = 0;
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("lat%0d_first_rsp_cycle", lat_of(g)), 160'(first_rise[g]), 160'(lat_of(g) + 1));
            chk($sformatf("lat%0d_result", lat_of(g)), 160'(first_res[g]), 160'(64'h1_0000_0000));
            chk($sformatf("lat%0d_period", lat_of(g)), 160'(second_rise[g] - first_rise[g]),
                160'(lat_of(g) + 2));
        end
        for (int i = 0; i < 20; i++) cyc();

        // Valid withdrawal: req1 loses the tie once, then drops valid.
        do_reset();
        req0_valid = 1; req0_op = 2'd0; req0_a = 1; req0_b = 1;
        req1_valid = 1; req1_op = 2'd1; req1_a = 5; req1_b = 1;
        cyc();
        req0_valid = 0; req1_valid = 0;
        id1_rsp = 0; id1_rdy = (snap_r1[0]) ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (snap_rv[0] && snap_id[0]) id1_rsp++;
            if (snap_r1[0]) id1_rdy++;
        end
        chk("withdraw_no_id1_rsp", 160'(id1_rsp), 160'(0));
        chk("withdraw_no_req1_ready", 160'(id1_rdy), 160'(0));
        chk("withdraw_req0_result", 160'({rid[0], r_res[0]}), 160'({1'b0, RW'(2)}));

        // Randomized traffic with occasional reset, checked against the model.
        do_reset();
        rsp_count = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                rst_n = 0;
                model_reset();
            end else begin
                rst_n = 1;
            end
            req0_valid = ($urandom_range(0, 99) < 55);
            req1_valid = ($urandom_range(0, 99) < 55);
            req0_op = 2'($urandom_range(0, 3)); req1_op = 2'($urandom_range(0, 3));
            req0_a = $urandom(); req0_b = $urandom_range(0, 9) == 0 ? '0 : $urandom();
            req1_a = $urandom(); req1_b = $urandom_range(0, 9) == 0 ? '0 : $urandom();
            rsp_ready = ($urandom_range(0, 99) < 65);
            cyc();
            if (snap_rv[0] && rsp_ready && rst_n) rsp_count++;
        end
        rst_n = 1;
        idle_inputs();
        rsp_ready = 1;
        for (int i = 0; i < 5; i++) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_arbiter.md
# calc_arbiter

Two-port round-robin arbiter and sequencer for the shared calculator datapath. It accepts operation requests from two independent requesters over valid/ready handshakes and launches one operation at a time into the calculator. It waits the calculator's fixed pipeline latency, captures the 2*WIDTH-bit result, and returns it with the requester ID over a valid/ready response channel. It sits between the front-end input logic (pin/I2C decode) and the calculator instance.

## Interface
Parameters:
- WIDTH, 32, operand width; result width is 2*WIDTH
- LATENCY, 2, clock edges from calc_* launch to calc_result valid; legal range 1..15

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle
- req0_op  in  2  requester 0 operation code
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as port 0, for requester 1
- calc_op  out  2  registered operation to calculator
- calc_a, calc_b  out  WIDTH  registered operands to calculator
- calc_result  in  2*WIDTH  calculator result
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester that issued this result
- rsp_result  out  2*WIDTH  captured result
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, WAIT, RESP. Reset state IDLE.
- IDLE: reqN_ready = 1 combinationally only for the granted requester, only in IDLE. Otherwise 0.
  - Grant: if both valid, grant requester != last_grant; if one valid, grant it; if none, stay.
  - On the handshake edge: calc_op/a/b <= granted inputs; rsp_id <= granted index; last_grant <= granted index; cnt <= LATENCY-1; go WAIT.
- WAIT: if cnt == 0, rsp_result <= calc_result, go RESP; else cnt <= cnt-1. Requests are ignored (both ready = 0).
- RESP: rsp_valid = 1; rsp_id/rsp_result stable. On rsp_valid && rsp_ready edge, go IDLE.
- calc_* hold their last launched values outside the launch edge. They are never modified in WAIT or RESP.
- Op codes pass through unmodified. The block has no arithmetic; width extension is the front end's job.
- Reset values: req0_ready = req1_ready = 0 while rst_n low, then per IDLE rule; calc_op = 0; calc_a = calc_b = 0; rsp_valid = 0; rsp_id = 0; rsp_result = 0; busy = 0; last_grant = 1 (requester 0 wins the first tie); cnt = 0.
- Reset mid-operation (WAIT or RESP) drops the in-flight operation and response. No response is ever produced for it.

## Timing
- Launch at edge k. Result is sampled at edge k+LATENCY. rsp_valid rises after edge k+LATENCY.
- Response consumed at edge m. IDLE from m; earliest next launch at edge m+1.
- Minimum period, rsp_ready held high: LATENCY+2 cycles per operation.
- A requester may hold valid high across WAIT/RESP. Its request is accepted on a later IDLE cycle, with operands sampled at the acceptance edge.
- A requester may drop valid before acceptance without effect. The grant is re-evaluated every IDLE cycle.
- Simultaneous valid on both ports with back-to-back traffic strictly alternates 0,1,0,1...
- rsp_ready low: RESP holds indefinitely. No new request is accepted, and calc_* are unchanged.

## Test plan
Bench uses a behavioural calculator with LATENCY-edge delay and ops 00 add, 01 sub, 10 mul, 11 div.
- Single request: req0 op=10, a=12, b=5, rsp_ready=1 -> req0_ready one cycle; rsp_valid exactly LATENCY edges after launch with rsp_result=60, rsp_id=0; busy high for LATENCY+1 cycles.
- Contention: both valid continuously after reset, req0 add 3+4, req1 sub 9-2 -> order rsp_id 0 (7), 1 (7), 0, 1...; never two grants in a row to the same port while the other is waiting.
- Backpressure: rsp_ready=0 for 10 cycles during RESP with req1 valid -> rsp_result/rsp_id stable, req1_ready=0, calc_* unchanged; req1 accepted the cycle after rsp_ready handshake.
- Reset mid-WAIT: assert rst_n low during WAIT -> all outputs at reset values immediately; after release, no stray rsp_valid; next req0 processes normally.
- LATENCY=1 and LATENCY=15 builds: add 0xFFFFFFFF+1 -> rsp_result=64'h1_0000_0000 sampled exactly at launch+LATENCY; period LATENCY+2.
- Valid withdrawal: req1 valid one IDLE cycle while req0 is granted (tie, last_grant=1) then dropped -> req1 never granted, no response with rsp_id=1.
